regfile_port_sched: RTL and testbench

- Sequencer/arbiter for the 16x16 single-port `reg_file`, which has one shared `addr`, a `we` strobe, `data` input and `value` output.
- Shares that single port between two requesters:
  - the operand-fetch stage, which needs two source registers read back-to-back;
  - the writeback stage, which needs one register written.
- Owns all reg_file port signals.
- Serialises accesses through a small FSM with write-first priority and alternation fairness.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_arb2.sv | 41 ++++
 rtl/regfile_port_sched.sv | 122 ++++++++++++
 tb/tb_regfile_port_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types for the register-file port scheduler: default widths,
// sequencer state encoding and arbiter grant encoding.
package regfile_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_A,
        RD_B,
        RD_W,
        DONE
    } state_t;

    localparam logic GRANT_WB = 1'b0;
    localparam logic GRANT_RD = 1'b1;

endpackage

// File: rtl/regfile_arb2.sv
// Two-requester arbiter: writeback wins a tie unless it won the previous
// grant, so neither side can be starved for more than one access.
module regfile_arb2
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic wb_req,
    input  logic rd_req,
    input  logic gnt_en,
    output logic gnt_wb,
    output logic gnt_rd
);

    logic last_grant;

    always_comb begin
        gnt_wb = 1'b0;
        gnt_rd = 1'b0;
        if (wb_req && rd_req) begin
            if (last_grant == GRANT_WB) gnt_rd = 1'b1;
            else                        gnt_wb = 1'b1;
        end else if (wb_req) begin
            gnt_wb = 1'b1;
        end else if (rd_req) begin
            gnt_rd = 1'b1;
        end
    end

    // Grant history only advances when the sequencer actually takes a decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GRANT_WB;
        end else if (gnt_en && gnt_wb) begin
            last_grant <= GRANT_WB;
        end else if (gnt_en && gnt_rd) begin
            last_grant <= GRANT_RD;
        end
    end

endmodule

// File: rtl/regfile_port_sched.sv
// Sequencer sharing the single reg_file port between operand fetch (two
// back-to-back reads) and writeback (one write). All outputs are registered.
module regfile_port_sched
    import regfile_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int RD_LAT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic          rd_ack,
    output logic          rd_done,
    output logic [DW-1:0] rd_data_a,
    output logic [DW-1:0] rd_data_b,
    input  logic          wb_req,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          wb_ack,
    output logic          rf_we,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_data,
    input  logic [DW-1:0] rf_value
);

    if (RD_LAT != 0 && RD_LAT != 1) begin : g_bad_rd_lat
        $error("regfile_port_sched: RD_LAT must be 0 or 1");
    end

    state_t        state;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] stage_a;
    logic          arb_en;
    logic          wb_pend;
    logic          gnt_wb;
    logic          gnt_rd;

    // In WR the pending wb_req is the one being served this cycle.
    assign arb_en  = (state == IDLE) || (state == WR) || (state == DONE);
    assign wb_pend = wb_req && (state != WR);

    regfile_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .wb_req (wb_pend),
        .rd_req (rd_req),
        .gnt_en (arb_en),
        .gnt_wb (gnt_wb),
        .gnt_rd (gnt_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rf_we     <= 1'b0;
            rf_addr   <= '0;
            rf_data   <= '0;
            rd_ack    <= 1'b0;
            rd_done   <= 1'b0;
            wb_ack    <= 1'b0;
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            rf_we   <= 1'b0;
            rd_ack  <= 1'b0;
            rd_done <= 1'b0;
            wb_ack  <= 1'b0;
            case (state)
                IDLE, WR, DONE: begin
                    if (gnt_wb) begin
                        state   <= WR;
                        rf_we   <= 1'b1;
                        rf_addr <= wb_addr;
                        rf_data <= wb_data;
                        wb_ack  <= 1'b1;
                    end else if (gnt_rd) begin
                        state   <= RD_A;
                        rf_addr <= rd_addr_a;
                        rd_ack  <= 1'b1;
                    end else begin
                        state   <= IDLE;
                    end
                end
                RD_A: begin
                    state   <= RD_B;
                    rf_addr <= addr_b;
                end
                RD_B: begin
                    if (RD_LAT == 0) begin
                        state     <= DONE;
                        rd_data_a <= stage_a;
                        rd_data_b <= rf_value;
                        rd_done   <= 1'b1;
                    end else begin
                        state     <= RD_W;
                    end
                end
                RD_W: begin
                    state     <= DONE;
                    rd_data_a <= stage_a;
                    rd_data_b <= rf_value;
                    rd_done   <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand staging; operand A arrives one state later with a registered file.
    always_ff @(posedge clk) begin
        if (arb_en && !gnt_wb && gnt_rd) begin
            addr_b <= rd_addr_b;
        end
        if ((RD_LAT == 0 && state == RD_A) || (RD_LAT == 1 && state == RD_B)) begin
            stage_a <= rf_value;
        end
    end

endmodule

// File: tb/tb_regfile_port_sched.sv
// Bench for regfile_port_sched: reg_file models, requester tasks and a
// scoreboard of expected operand pairs built from a shadow copy of the file.
module tb_regfile_port_sched;

    localparam int DW = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, rf_clr;
    logic          rd_req, wb_req, rd_ack, rd_done, wb_ack, rf_we;
    logic [AW-1:0] rd_addr_a, rd_addr_b, wb_addr, rf_addr;
    logic [DW-1:0] wb_data, rd_data_a, rd_data_b, rf_data, rf_value;
    logic          rd_req1, wb_req1, rd_ack1, rd_done1, wb_ack1, rf_we1;
    logic [AW-1:0] rd_addr_a1, rd_addr_b1, wb_addr1, rf_addr1;
    logic [DW-1:0] wb_data1, rd_data_a1, rd_data_b1, rf_data1, rf_value1;

    regfile_port_sched #(.DW(DW), .AW(AW), .RD_LAT(0)) u_dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_ack(rd_ack), .rd_done(rd_done), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ack(wb_ack),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .rf_value(rf_value)
    );

    regfile_port_sched #(.DW(DW), .AW(AW), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .rd_req(rd_req1), .rd_addr_a(rd_addr_a1), .rd_addr_b(rd_addr_b1),
        .rd_ack(rd_ack1), .rd_done(rd_done1), .rd_data_a(rd_data_a1), .rd_data_b(rd_data_b1),
        .wb_req(wb_req1), .wb_addr(wb_addr1), .wb_data(wb_data1), .wb_ack(wb_ack1),
        .rf_we(rf_we1), .rf_addr(rf_addr1), .rf_data(rf_data1), .rf_value(rf_value1)
    );

    // reg_file models: combinational read for u_dut, registered read for u_dut1
    logic [DW-1:0] mem0 [16];
    logic [DW-1:0] mem1 [16];
    logic [DW-1:0] rdq1;

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 16; i++) mem0[i] <= '0;
        end else if (rf_we) begin
            mem0[rf_addr] <= rf_data;
        end
    end
    assign rf_value = mem0[rf_addr];

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 16; i++) mem1[i] <= '0;
        end else if (rf_we1) begin
            mem1[rf_addr1] <= rf_data1;
        end
        rdq1 <= mem1[rf_addr1];
    end
    assign rf_value1 = rdq1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          e;
    logic [DW-1:0] shadow [16];
    byte           grant_log[$];
    int            cyc = 0;
    int            ack_cyc = 0, done_cyc = 0, wback_cyc = 0, done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor for u_dut: samples on the falling edge, before drivers move.
    initial begin
        forever begin
            @(negedge clk);
            if (rf_clr) begin
                for (int i = 0; i < 16; i++) shadow[i] = '0;
            end
            if (rst) begin
                exp_q.delete();
            end else begin
                if (rf_we || wb_ack) begin
                    chk("we_ack_pair", 32'({rf_we, wb_ack}), 32'h3);
                    chk("wr_addr", 32'(rf_addr), 32'(wb_addr));
                    chk("wr_data", 32'(rf_data), 32'(wb_data));
                    shadow[wb_addr] = wb_data;
                    wback_cyc = cyc;
                    grant_log.push_back("W");
                end
                if (rd_ack) begin
                    exp_q.push_back({shadow[rd_addr_a], shadow[rd_addr_b]});
                    ack_cyc = cyc;
                    grant_log.push_back("R");
                end
                if (rd_done) begin
                    done_cyc = cyc;
                    done_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("rd_done_unexpected", 32'(1), 32'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("rd_data_a", 32'(rd_data_a), 32'(e.a));
                        chk("rd_data_b", 32'(rd_data_b), 32'(e.b));
                        chk("rd_latency", 32'(cyc - ack_cyc), 32'(2));
                    end
                end
            end
        end
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int waits);
        waits   = 0;
        wb_addr = a;
        wb_data = d;
        wb_req  = 1'b1;
        do begin
            @(negedge clk); #1;
            waits++;
        end while (!wb_ack && waits < 50);
        chk("wb_ack_seen", 32'(wb_ack), 32'(1));
        wb_req = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] b);
        int waits = 0;
        rd_addr_a = a;
        rd_addr_b = b;
        rd_req    = 1'b1;
        do begin
            @(negedge clk); #1;
            waits++;
        end while (!rd_ack && waits < 50);
        chk("rd_ack_seen", 32'(rd_ack), 32'(1));
        rd_req = 1'b0;
    endtask

    task automatic wait_quiet();
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk); #1;
            n++;
        end
        chk("reads_drained", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, w2, s, n, dc;
        rst = 1'b1; rf_clr = 1'b1;
        rd_req = 1'b0; wb_req = 1'b0; rd_addr_a = '0; rd_addr_b = '0; wb_addr = '0; wb_data = '0;
        rd_req1 = 1'b0; wb_req1 = 1'b0; rd_addr_a1 = '0; rd_addr_b1 = '0; wb_addr1 = '0; wb_data1 = '0;
        @(negedge clk); @(negedge clk); #1;
        chk("reset_ctrl", 32'({rf_we, rd_ack, rd_done, wb_ack}), 32'(0));
        chk("reset_rf_addr", 32'(rf_addr), 32'(0));
        chk("reset_rd_data", 32'({rd_data_a, rd_data_b}), 32'(0));
        chk("reset_ctrl_lat1", 32'({rf_we1, rd_ack1, rd_done1, wb_ack1}), 32'(0));
        rst = 1'b0; rf_clr = 1'b0;

        // 1: single write, one-cycle grant, strobe drops afterwards
        do_write(4'd4, 16'hF0F0, w);
        chk("wb_latency", 32'(w), 32'(1));
        @(negedge clk); #1;
        chk("we_drop", 32'(rf_we), 32'(0));

        // 2: read back the written register and a cleared one
        do_read(4'd4, 4'd3);
        wait_quiet();
        chk("t2_data_a", 32'(rd_data_a), 32'hF0F0);
        chk("t2_data_b", 32'(rd_data_b), 32'h0000);

        // 3: simultaneous requests after a read grant: write goes first
        s = grant_log.size();
        fork
            do_write(4'd5, 16'h1234, w);
            do_read(4'd5, 4'd5);
        join
        wait_quiet();
        chk("t3_first_grant", 32'(grant_log[s]), 32'("W"));
        chk("t3_second_grant", 32'(grant_log[s + 1]), 32'("R"));
        chk("t3_data", 32'({rd_data_a, rd_data_b}), 32'h12341234);

        // 4: both requesters saturated after a write: strict alternation from RD
        do_write(4'd7, 16'h0777, w);
        s = grant_log.size();
        fork
            begin
                for (int i = 0; i < 4; i++) do_read(4'(8 + i), 4'd7);
            end
            begin
                int ww;
                for (int i = 0; i < 4; i++) do_write(4'(8 + i), 16'(16'hA000 + i), ww);
            end
        join
        wait_quiet();
        chk("t4_grant_count", 32'(grant_log.size() - s), 32'(8));
        for (int j = 0; j < 8 && s + j < grant_log.size(); j++) begin
            chk("t4_alternate", 32'(grant_log[s + j]), (j % 2 == 0) ? 32'("R") : 32'("W"));
        end

        // 5: writeback raised during RD_B waits for DONE and leaves operands intact
        fork
            do_read(4'd9, 4'd8);
            begin
                n = 0;
                do begin
                    @(negedge clk); #1;
                    n++;
                end while (!rd_ack && n < 50);
                @(negedge clk); #1;
                do_write(4'd9, 16'h5555, w2);
            end
        join
        wait_quiet();
        chk("t5_wb_after_done", 32'(wback_cyc - done_cyc), 32'(1));
        chk("t5_operand_a_kept", 32'(rd_data_a), 32'hA001);
        chk("t5_operand_b_kept", 32'(rd_data_b), 32'hA000);

        // 6: reset during RD_B aborts the read
        do_read(4'd2, 4'd4);
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        chk("t6_rst_ctrl", 32'({rf_we, rd_ack, rd_done, wb_ack}), 32'(0));
        chk("t6_rst_rf", 32'({rf_addr, rf_data}), 32'(0));
        chk("t6_rst_rd_data", 32'({rd_data_a, rd_data_b}), 32'(0));
        rst = 1'b0;
        dc = done_cnt;
        repeat (6) begin
            @(negedge clk); #1;
        end
        chk("t6_no_done", 32'(done_cnt - dc), 32'(0));
        do_read(4'd4, 4'd3);
        wait_quiet();
        chk("t6_recover", 32'({rd_data_a, rd_data_b}), 32'hF0F00000);

        // Registered-read file: same write/read pair, one extra cycle to rd_done
        wb_addr1 = 4'd4; wb_data1 = 16'hF0F0; wb_req1 = 1'b1; n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!wb_ack1 && n < 50);
        chk("l1_wb_latency", 32'(n), 32'(1));
        chk("l1_wb_fields", 32'({rf_we1, rf_addr1, rf_data1}), 32'({1'b1, 4'd4, 16'hF0F0}));
        wb_req1 = 1'b0;
        rd_addr_a1 = 4'd4; rd_addr_b1 = 4'd3; rd_req1 = 1'b1; n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!rd_ack1 && n < 50);
        chk("l1_rd_ack", 32'(rd_ack1), 32'(1));
        rd_req1 = 1'b0; n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!rd_done1 && n < 50);
        chk("l1_rd_latency", 32'(n), 32'(3));
        chk("l1_rd_data", 32'({rd_data_a1, rd_data_b1}), 32'hF0F00000);
        @(negedge clk); #1;
        chk("l1_done_pulse", 32'(rd_done1), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
